// File: rtl/counter_sched.sv
// Round-robin scheduler that shares one loadable counter between two requesters:
// it loads each job's start value, runs len increments and returns the final count.
module counter_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_start,
   input  logic [WIDTH-1:0] req0_len,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_start,
   input  logic [WIDTH-1:0] req1_len,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_value,
   output logic             cnt_load,
   output logic             cnt_en,
   output logic             cnt_oe,
   output logic [WIDTH-1:0] cnt_load_data,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             busy,
   output logic             owner
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             grant0, grant1;

   // last_q names the requester served most recently, so a tie goes to the other one.
   // Grants are suppressed while rst is high so reset beats an acceptance.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      start_d     = start_q;
      len_d       = len_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               owner_d = grant1;
               last_d  = grant1;
               start_d = grant1 ? req1_start : req0_start;
               len_d   = grant1 ? req1_len : req0_len;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (len_q == '0) begin
               state_d = RESP;
            end else begin
               state_d     = RUN;
               remaining_d = len_q;
            end
         end
         RUN: begin
            remaining_d = remaining_q - WIDTH'(1);
            if (remaining_q == WIDTH'(1)) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         start_q     <= '0;
         len_q       <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         start_q     <= start_d;
         len_q       <= len_d;
         remaining_q <= remaining_d;
      end
   end

   // Counter controls decode straight from the state register; the counter is frozen in RESP.
   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign cnt_load      = (state_q == LOAD);
   assign cnt_load_data = (state_q == LOAD) ? start_q : '0;
   assign cnt_en        = (state_q == RUN);
   assign cnt_oe        = (state_q != IDLE);
   assign rsp_valid     = (state_q == RESP);
   assign rsp_id        = (state_q == RESP) && owner_q;
   assign rsp_value     = (state_q == RESP) ? cnt_q : '0;
   assign busy          = (state_q != IDLE);
   assign owner         = owner_q;

endmodule
